// File: rtl/psum_accumulator.sv
// psum_accumulator: drives the 1-D convolution PE one input channel at a
// time, drains its Psum buffer after each run, accumulates the partial sums
// across channels and streams the final sums out over valid/ready.
module psum_accumulator #(
  parameter int PSUM_WIDTH = 16,
  parameter int OUT_WIDTH  = 24,
  parameter int DEPTH      = 8,
  parameter int CNT_SIZE   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DEPTH):0]       num_psum,
  input  logic [CNT_SIZE-1:0]          num_channels,
  output logic                         pe_start,
  input  logic                         pe_done,
  output logic                         ren_Psum_buffer,
  input  logic signed [PSUM_WIDTH-1:0] Psum_out,
  output logic signed [OUT_WIDTH-1:0]  result_data,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         result_last,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_READ,
    S_DRAIN,
    S_EMIT,
    S_FIN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]       p_len;      // words per channel, clamped to DEPTH
  logic [CNT_SIZE-1:0] c_len;      // channels to accumulate
  logic [CNT_SIZE-1:0] ch_cnt;     // channels fully accumulated so far
  logic [CW-1:0]       rd_idx;     // buffer read index during READ
  logic [CW-1:0]       emit_idx;   // result index during EMIT
  logic                cap_valid;  // Psum_out holds a word to accumulate
  logic [AW-1:0]       cap_idx;    // accumulator entry for that word
  logic                pe_done_q;  // previous-cycle pe_done

  logic signed [OUT_WIDTH-1:0] acc [DEPTH];

  logic [CW-1:0]               p_clamped;
  logic [CNT_SIZE-1:0]         ch_cnt_inc;
  logic                        pe_done_rise;
  logic                        emit_last;
  logic signed [OUT_WIDTH-1:0] psum_ext;

  assign p_clamped    = (num_psum > CW'(DEPTH)) ? CW'(DEPTH) : num_psum;
  assign ch_cnt_inc   = ch_cnt + 1'b1;
  // Only a fresh rising edge counts, so a done level left high by the
  // previous channel cannot start a read of stale data.
  assign pe_done_rise = pe_done & ~pe_done_q;
  assign emit_last    = (emit_idx == p_len - 1'b1);
  assign psum_ext     = {{(OUT_WIDTH - PSUM_WIDTH){Psum_out[PSUM_WIDTH-1]}}, Psum_out};

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_next      = state;
    pe_start        = 1'b0;
    ren_Psum_buffer = 1'b0;
    result_valid    = 1'b0;
    result_last     = 1'b0;
    result_data     = '0;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (p_clamped == '0 || num_channels == '0) ? S_FIN : S_KICK;
        end
      end
      S_KICK: begin
        pe_start   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (pe_done_rise) state_next = S_READ;
      end
      S_READ: begin
        ren_Psum_buffer = 1'b1;
        if (rd_idx == p_len - 1'b1) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        state_next = (ch_cnt_inc < c_len) ? S_KICK : S_EMIT;
      end
      S_EMIT: begin
        result_valid = 1'b1;
        result_last  = emit_last;
        result_data  = acc[emit_idx[AW-1:0]];
        if (result_ready && emit_last) state_next = S_FIN;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register, launch parameters, counters and the read-capture pipe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_IDLE;
      p_len     <= '0;
      c_len     <= '0;
      ch_cnt    <= '0;
      rd_idx    <= '0;
      emit_idx  <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      pe_done_q <= 1'b1;
    end else begin
      state     <= state_next;
      pe_done_q <= pe_done;
      // The buffer answers one cycle after ren, so remember which entry the
      // word now arriving on Psum_out belongs to.
      cap_valid <= ren_Psum_buffer;
      cap_idx   <= rd_idx[AW-1:0];
      case (state)
        S_IDLE: begin
          if (start) begin
            p_len  <= p_clamped;
            c_len  <= num_channels;
            ch_cnt <= '0;
          end
        end
        S_KICK:  rd_idx <= '0;
        S_READ:  rd_idx <= rd_idx + 1'b1;
        S_DRAIN: begin
          ch_cnt   <= ch_cnt_inc;
          emit_idx <= '0;
        end
        S_EMIT: begin
          if (result_ready) emit_idx <= emit_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Accumulator array: channel 0 overwrites, later channels add with wrap.
  always_ff @(posedge clk) begin
    // NOTE: this array is small and must read as zero after reset, so it is
    // reset explicitly; large RAM-style arrays are normally left unreset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (cap_valid) begin
      acc[cap_idx] <= (ch_cnt == '0) ? psum_ext : acc[cap_idx] + psum_ext;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed testbench for psum_accumulator with a behavioural PE model
// (1-cycle-latency Psum buffer, pe_done level driver) and stream monitor.
module tb_psum_accumulator;

  localparam int PW    = 16;
  localparam int OW    = 24;
  localparam int DEPTH = 8;
  localparam int CS    = 9;
  localparam int CW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [CW-1:0]        num_psum;
  logic [CS-1:0]        num_channels;
  logic                 pe_start;
  logic                 pe_done;
  logic                 ren;
  logic signed [PW-1:0] psum;
  logic signed [OW-1:0] result_data;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_last;
  logic                 busy;
  logic                 done;

  psum_accumulator #(
    .PSUM_WIDTH(PW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .CNT_SIZE(CS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_psum(num_psum),
    .num_channels(num_channels), .pe_start(pe_start), .pe_done(pe_done),
    .ren_Psum_buffer(ren), .Psum_out(psum), .result_data(result_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_last(result_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- PE model ----------------
  logic signed [PW-1:0] pe_mem [4][DEPTH];
  bit hold_mode = 1'b0;
  int pe_chan = 0, chan_sel = 0, rd_ptr = 0;
  int delay = 0, hold_cnt = 0, raise_cyc = 0, bad_ren = 0;
  bit hold_phase = 1'b0;

  // Psum buffer: registered read, one cycle after ren.
  always @(posedge clk) begin
    if (rst) begin
      psum   <= '0;
      rd_ptr <= 0;
    end else begin
      if (start && !busy) pe_chan <= 0;
      if (pe_start) begin
        chan_sel <= (pe_chan < 4) ? pe_chan : 3;
        pe_chan  <= pe_chan + 1;
        rd_ptr   <= 0;
      end else if (ren) begin
        psum   <= pe_mem[chan_sel][rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // pe_done level: normally drops on pe_start and rises two cycles later;
  // in hold mode it stays high for a while first, then pulses low/high.
  always @(negedge clk) begin
    if (rst) begin
      pe_done    = 1'b0;
      delay      = 0;
      hold_cnt   = 0;
      hold_phase = 1'b0;
    end else begin
      if (ren && hold_phase) bad_ren++;
      if (pe_start) begin
        if (hold_mode) begin
          hold_cnt   = 3;
          hold_phase = 1'b1;
        end else begin
          pe_done = 1'b0;
          delay   = 2;
        end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) begin
          pe_done = 1'b0;
          delay   = 1;
        end
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          pe_done    = 1'b1;
          hold_phase = 1'b0;
          raise_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int n_pe_start = 0, n_ren = 0, n_done = 0, done_cyc = 0, run_len = 0, n_unstable = 0;
  int runs[$];
  logic signed [OW-1:0] hs_data[$];
  bit hs_last[$];
  int hs_cyc[$];
  bit held = 1'b0;
  logic signed [OW-1:0] held_data;
  bit held_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (pe_start) n_pe_start++;
      if (ren) begin
        n_ren++;
        run_len++;
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (result_valid && result_ready) begin
        hs_data.push_back(result_data);
        hs_last.push_back(result_last);
        hs_cyc.push_back(cyc);
      end
      if (held && (!result_valid || result_data != held_data || result_last != held_last))
        n_unstable++;
      held      = result_valid && !result_ready;
      held_data = result_data;
      held_last = result_last;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [CW-1:0] np, input logic [CS-1:0] nc);
    num_psum     = np;
    num_channels = nc;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (n_done > d0) break;
      tick();
    end
    check({tag, "_done"}, n_done - d0, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({pe_start, ren, result_data, result_valid, result_last, busy, done});
  endfunction

  int b_hs, b_run, b_ps, b_ren, b_done, b_bad, b_unst, s_cyc;
  int r0, p0, lasts;
  bit seen;

  task automatic take_bases();
    b_hs   = hs_data.size();
    b_run  = runs.size();
    b_ps   = n_pe_start;
    b_ren  = n_ren;
    b_done = n_done;
    b_bad  = bad_ren;
    b_unst = n_unstable;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    num_psum     = '0;
    num_channels = '0;
    result_ready = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < DEPTH; i++) pe_mem[c][i] = '0;
    tick();
    tick();
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;
    tick();

    // Basic single channel
    pe_mem[0][0] = 16'sd5;
    pe_mem[0][1] = -16'sd3;
    pe_mem[0][2] = 16'sd100;
    pe_mem[0][3] = 16'sd0;
    take_bases();
    launch(4, 1);
    wait_done(b_done, 200, "basic");
    tick();
    check("basic_pe_start", n_pe_start - b_ps, 1);
    check("basic_ren", n_ren - b_ren, 4);
    check("basic_runs", runs.size() - b_run, 1);
    check("basic_run_len", runs[b_run], 4);
    check("basic_hs", hs_data.size() - b_hs, 4);
    check("basic_d0", hs_data[b_hs], 5);
    check("basic_d1", hs_data[b_hs+1], -3);
    check("basic_d1_raw", 32'(hs_data[b_hs+1][OW-1:0]), 32'h00FFFFFD);
    check("basic_d2", hs_data[b_hs+2], 100);
    check("basic_d3", hs_data[b_hs+3], 0);
    check("basic_last", {hs_last[b_hs], hs_last[b_hs+1], hs_last[b_hs+2], hs_last[b_hs+3]}, 4'b0001);
    check("basic_latency", hs_cyc[b_hs] - raise_cyc, 6);
    check("basic_done_delay", done_cyc - hs_cyc[b_hs+3], 1);

    // Multi-channel accumulation
    pe_mem[0][0] = 16'sd1;    pe_mem[0][1] = 16'sd2;
    pe_mem[1][0] = 16'sd10;   pe_mem[1][1] = 16'sd20;
    pe_mem[2][0] = -16'sd100; pe_mem[2][1] = 16'sd7;
    take_bases();
    launch(2, 3);
    wait_done(b_done, 300, "multi");
    tick();
    check("multi_pe_start", n_pe_start - b_ps, 3);
    check("multi_hs", hs_data.size() - b_hs, 2);
    check("multi_d0", hs_data[b_hs], -89);
    check("multi_d1", hs_data[b_hs+1], 29);
    check("multi_last", {hs_last[b_hs], hs_last[b_hs+1]}, 2'b01);

    // Backpressure, with a start pulse while busy that must be ignored
    pe_mem[0][0] = 16'sd11;
    pe_mem[0][1] = -16'sd22;
    pe_mem[0][2] = 16'sd33;
    result_ready = 1'b0;
    take_bases();
    launch(3, 1);
    tick();
    num_psum     = 1;
    num_channels = 5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("bp_valid_seen", 32'(seen), 1);
    begin
      bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
        result_ready = pat[i];
        tick();
      end
    end
    result_ready = 1'b1;
    wait_done(b_done, 50, "bp");
    tick();
    check("bp_busy_start_ignored", n_pe_start - b_ps, 1);
    check("bp_hs", hs_data.size() - b_hs, 3);
    check("bp_d0", hs_data[b_hs], 11);
    check("bp_d1", hs_data[b_hs+1], -22);
    check("bp_d2", hs_data[b_hs+2], 33);
    check("bp_last", {hs_last[b_hs], hs_last[b_hs+1], hs_last[b_hs+2]}, 3'b001);
    check("bp_stable", n_unstable - b_unst, 0);

    // Held pe_done level across channels plus num_psum clamp
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) pe_mem[c][i] = 16'(i + 1);
    hold_mode = 1'b1;
    take_bases();
    launch(12, 2);
    wait_done(b_done, 400, "edge");
    tick();
    hold_mode = 1'b0;
    check("edge_no_early_read", bad_ren - b_bad, 0);
    check("edge_pe_start", n_pe_start - b_ps, 2);
    check("edge_runs", runs.size() - b_run, 2);
    check("edge_run0", runs[b_run], 8);
    check("edge_run1", runs[b_run+1], 8);
    check("edge_hs", hs_data.size() - b_hs, 8);
    lasts = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("edge_d%0d", i), hs_data[b_hs+i], 2 * (i + 1));
      lasts += int'(hs_last[b_hs+i]);
    end
    check("edge_last_count", lasts, 1);
    check("edge_last_pos", 32'(hs_last[b_hs+7]), 1);

    // Wrap-around across 256 and 257 channels
    for (int c = 0; c < 4; c++) pe_mem[c][0] = 16'sd32767;
    take_bases();
    launch(1, 256);
    wait_done(b_done, 4000, "wrap256");
    tick();
    check("wrap256_pe_start", n_pe_start - b_ps, 256);
    check("wrap256_d", hs_data[b_hs], 8388352);
    take_bases();
    launch(1, 257);
    wait_done(b_done, 4000, "wrap257");
    tick();
    check("wrap257_d", hs_data[b_hs], -8356097);

    // Degenerate launches
    take_bases();
    s_cyc = cyc;
    launch(4, 0);
    wait_done(b_done, 10, "c0");
    check("c0_done_delay", done_cyc - s_cyc, 1);
    take_bases();
    launch(0, 3);
    wait_done(b_done, 10, "p0");
    tick();
    check("degen_pe_start", n_pe_start - b_ps, 0);
    check("degen_ren", n_ren - b_ren, 0);

    // Reset in the middle of READ
    launch(4, 1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ren) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("rst_read_seen", 32'(seen), 1);
    rst = 1'b1;
    tick();
    check("rst_mid_outs", all_outs(), 0);
    r0  = n_ren;
    p0  = n_pe_start;
    rst = 1'b0;
    repeat (6) tick();
    check("rst_no_ren", n_ren - r0, 0);
    check("rst_no_pe_start", n_pe_start - p0, 0);
    check("rst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
